// File: rtl/median_win_feeder.sv
// Ring-buffer writer and window streamer feeding the median sorter.
// Each sample past warm-up triggers a read-back of the last WIN samples, oldest first.
module median_win_feeder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int WIN        = 5
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] win_data,
  output logic                  win_valid,
  output logic                  win_first,
  output logic                  win_last,
  input  logic                  win_ready
);

  localparam int FW    = $clog2(WIN + 1);
  localparam int CNT_W = $clog2(WIN);
  localparam logic [FW-1:0]         FILL_MAX = FW'(WIN);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WIN - 1);
  localparam logic [ADDR_WIDTH-1:0] WIN_M1   = ADDR_WIDTH'(WIN - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]         r_fill, w_fill_nxt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [DATA_WIDTH-1:0] r_win_data;
  logic                  r_win_valid, r_win_first, r_win_last;
  logic                  w_accept, w_load, w_rd_last;

  // Reset also masks the write strobe so the RAM sees no write while held in reset.
  assign w_accept   = (r_state == S_IDLE) && in_valid && !flush && !asyn_rst;
  assign w_load     = (r_state == S_READ) && (!r_win_valid || win_ready) && !flush;
  assign w_rd_last  = (r_rd_cnt == CNT_LAST);
  assign w_fill_nxt = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FW'(1);

  assign in_ready    = (r_state == S_IDLE);
  assign ram_wr_en   = w_accept;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = r_rd_ptr;
  assign win_data    = r_win_data;
  assign win_valid   = r_win_valid;
  assign win_first   = r_win_first;
  assign win_last    = r_win_last;

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (w_accept && (w_fill_nxt == FILL_MAX)) w_state_nxt = S_READ;
        S_READ:  if (w_load && w_rd_last) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rd_cnt    <= '0;
      r_win_data  <= '0;
      r_win_valid <= 1'b0;
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (flush) begin
      // History is dropped but wr_ptr and RAM contents are kept.
      r_fill      <= '0;
      r_win_valid <= 1'b0;
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        r_fill   <= w_fill_nxt;
        if (w_fill_nxt == FILL_MAX) begin
          // Oldest of the WIN newest samples, counting the one being written now.
          r_rd_ptr <= r_wr_ptr - WIN_M1;
          r_rd_cnt <= '0;
        end
      end
      if (w_load) begin
        r_win_data  <= ram_rd_data;
        r_win_valid <= 1'b1;
        r_win_first <= (r_rd_cnt == '0);
        r_win_last  <= w_rd_last;
        r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
        r_rd_cnt    <= w_rd_last ? '0 : r_rd_cnt + CNT_W'(1);
      end else if (r_win_valid && win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_win_feeder.sv
// Directed bench for median_win_feeder: warm-up, sliding, backpressure, flush, reset, wrap.
module tb_median_win_feeder;

  logic        wr_clk = 1'b0;
  logic        asyn_rst, flush, in_valid, in_ready, ram_wr_en;
  logic        win_valid, win_first, win_last, win_ready;
  logic [15:0] in_data, ram_wr_data, ram_rd_data, win_data;
  logic [3:0]  ram_wr_addr, ram_rd_addr;
  logic [15:0] mem [16];
  int          n_checks = 0;
  int          n_err = 0;

  median_win_feeder #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WIN(5)) dut (
    .wr_clk(wr_clk), .asyn_rst(asyn_rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .win_data(win_data), .win_valid(win_valid), .win_first(win_first),
    .win_last(win_last), .win_ready(win_ready)
  );

  always #5 wr_clk = ~wr_clk;

  // Distributed RAM: synchronous write, combinational read.
  always @(posedge wr_clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk); #1;
  endtask

  task automatic push(input int d, input int a);
    in_valid = 1'b1; in_data = 16'(d);
    #1;
    chk("wr_en", 32'(ram_wr_en), 1);
    chk("wr_addr", 32'(ram_wr_addr), a);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_quiet(input int d, input int a);
    push(d, a);
    chk("warm_valid", 32'(win_valid), 0);
    chk("warm_ready", 32'(in_ready), 1);
  endtask

  // Expects five loads of v0..v0+4 on consecutive edges; ra0<0 skips address checks.
  task automatic win_chk(input int v0, input int ra0);
    for (int k = 0; k < 5; k++) begin
      if (ra0 >= 0) chk("rd_addr", 32'(ram_rd_addr), (ra0 + k) % 16);
      step();
      chk("win_valid", 32'(win_valid), 1);
      chk("win_data", 32'(win_data), v0 + k);
      chk("win_first", 32'(win_first), (k == 0) ? 1 : 0);
      chk("win_last", 32'(win_last), (k == 4) ? 1 : 0);
      chk("win_in_ready", 32'(in_ready), (k == 4) ? 1 : 0);
    end
  endtask

  task automatic push_win(input int d, input int a, input int v0, input int ra0);
    push(d, a);
    chk("rd_in_ready", 32'(in_ready), 0);
    chk("rd_valid0", 32'(win_valid), 0);
    win_chk(v0, ra0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    asyn_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(win_valid), 0);
    chk("rst_data", 32'(win_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    asyn_rst = 1'b0;
    step();

    // Warm-up: samples 1..4 silent, sample 5 opens window 1..5
    for (int k = 1; k <= 4; k++) push_quiet(k, k - 1);
    push_win(5, 4, 1, 0);

    // Sliding windows
    push_win(6, 5, 2, 1);
    push_win(7, 6, 3, 2);

    // Backpressure on the third word of window 4..8
    push(8, 7);
    chk("bp_in_ready", 32'(in_ready), 0);
    step(); chk("bp_d0", 32'(win_data), 4);
    step(); chk("bp_d1", 32'(win_data), 5);
    step(); chk("bp_d2", 32'(win_data), 6);
    win_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", 32'(win_data), 6);
      chk("bp_hold_valid", 32'(win_valid), 1);
      chk("bp_hold_ready", 32'(in_ready), 0);
    end
    win_ready = 1'b1;
    step(); chk("bp_d3", 32'(win_data), 7); chk("bp_d3_ready", 32'(in_ready), 0);
    step(); chk("bp_d4", 32'(win_data), 8); chk("bp_d4_last", 32'(win_last), 1);
    chk("bp_done_ready", 32'(in_ready), 1);

    // Flush mid-READ of window 5..9
    push(9, 8);
    step(); chk("fl_d0", 32'(win_data), 5);
    step(); chk("fl_d1", 32'(win_data), 6);
    flush = 1'b1;
    #1 chk("fl_wr_en", 32'(ram_wr_en), 0);
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(win_valid), 0);
    chk("fl_first", 32'(win_first), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    for (int k = 10; k <= 13; k++) push_quiet(k, k - 1);
    push_win(14, 13, 10, 9);

    // Asynchronous reset mid-READ of window 11..15
    push(15, 14);
    step(); chk("rs_d0", 32'(win_data), 11);
    step(); chk("rs_d1", 32'(win_data), 12);
    #2;
    asyn_rst = 1'b1; in_valid = 1'b1;
    #1;
    chk("rs_valid", 32'(win_valid), 0);
    chk("rs_data", 32'(win_data), 0);
    chk("rs_first", 32'(win_first), 0);
    chk("rs_last", 32'(win_last), 0);
    chk("rs_in_ready", 32'(in_ready), 1);
    chk("rs_wr_en", 32'(ram_wr_en), 0);
    in_valid = 1'b0;
    step();
    asyn_rst = 1'b0;
    #1;

    // Wrap: after reset writes restart at 0; window for 18 spans 13,14,15,0,1
    for (int k = 1; k <= 20; k++) begin
      if (k < 5) push_quiet(k, (k - 1) % 16);
      else       push_win(k, (k - 1) % 16, k - 4, (k - 5) % 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/median_win_feeder.md
# median_win_feeder

Ring-buffer controller and window streamer in front of the median sorter. It accepts one audio sample at a time and writes it into an external distributed simple-dual-port RAM instance, which is configured with an unregistered read output. Once at least WIN samples have been stored, each new sample triggers a read-back of the latest WIN samples, oldest first. These samples are streamed to the downstream sorter over a valid/ready handshake, framed with first/last markers.

## Interface
- ADDR_WIDTH, 4 — ring-buffer address width (4–10); ring depth 2**ADDR_WIDTH
- DATA_WIDTH, 16 — sample width (1–256)
- WIN, 5 — window length, odd, 3 ≤ WIN ≤ 2**ADDR_WIDTH−1
- wr_clk  in  1  single clock for all logic; the RAM's wr_clk and rd_clk are both tied to it
- asyn_rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of window history
- in_data  in  DATA_WIDTH  input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr
- ram_wr_en  out  1  to RAM wr_en
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data; combinational read, same-cycle
- win_data  out  DATA_WIDTH  window sample
- win_valid  out  1  win_data valid
- win_first  out  1  oldest sample of the window
- win_last  out  1  newest sample of the window
- win_ready  in  1  sorter accepts win_data

## Operation
- **Registers:** wr_ptr (ADDR_WIDTH), rd_ptr (ADDR_WIDTH), fill (0..WIN, saturating), rd_cnt (0..WIN−1), state {IDLE, READ}, and an output register holding win_data, win_valid, win_first and win_last.
- **IDLE:**
  - in_ready=1.
  - Accept when in_valid && in_ready.
  - ram_wr_en = accept, ram_wr_addr = wr_ptr, ram_wr_data = in_data; all three are combinational.
  - On accept: wr_ptr += 1 (wraps modulo 2**ADDR_WIDTH); fill = min(fill+1, WIN).
  - If the updated fill == WIN: rd_ptr ← wr_ptr + 1 − WIN (mod 2**ADDR_WIDTH), rd_cnt ← 0, state → READ.
  - Otherwise remain in IDLE. Warm-up produces no output for the first WIN−1 samples.
- **READ:**
  - in_ready=0 and ram_wr_en=0; no write can happen while reading.
  - ram_rd_addr = rd_ptr.
  - Load condition: !win_valid || win_ready.
  - On load: win_data ← ram_rd_data, win_valid ← 1, win_first ← (rd_cnt==0), win_last ← (rd_cnt==WIN−1), rd_ptr += 1 (wraps), rd_cnt += 1.
  - On loading the word with rd_cnt==WIN−1: state → IDLE.
- **Output register:**
  - When win_valid && win_ready and no new load occurs, win_valid ← 0.
  - win_data, win_first and win_last hold their values until the next load.
- **ram_rd_addr in IDLE:** equals rd_ptr; it is don't-care for the RAM.
- **flush:**
  - Has priority over accept and load.
  - fill ← 0, state → IDLE, win_valid ← 0, win_first ← 0, win_last ← 0.
  - wr_ptr is unchanged and RAM contents are untouched. ram_wr_en=0 in the flush cycle.
- **Reset values:**
  - Registers: wr_ptr=0, rd_ptr=0, fill=0, rd_cnt=0, state=IDLE.
  - Outputs: win_data=0, win_valid=0, win_first=0, win_last=0, in_ready=1, ram_wr_en=0.
  - Reset mid-READ aborts the window immediately; the RAM array is not cleared.

## Timing
- Let the sample that completes fill==WIN be accepted in cycle T.
  - State is READ from edge T+1.
  - The first load happens at edge T+2 (win_first=1).
  - With win_ready=1 held, one word loads per cycle; win_last=1 after edge T+WIN+1.
  - State returns to IDLE at edge T+WIN+1, so in_ready=1 in cycle T+WIN+1.
- Steady-state throughput with win_ready=1 is one input sample per WIN+1 cycles.
- Backpressure: win_ready=0 while win_valid=1 freezes rd_ptr, rd_cnt, win_data and the flags. in_ready stays 0 until the last word has been loaded.
- The last word may still be pending (win_valid=1, win_ready=0) after the return to IDLE. A new accept is still allowed, but the next READ does not load until the load condition holds.
- Wrap-around: the window may span address 2**ADDR_WIDTH−1 → 0. Words are read in ascending modulo order.

## Test plan
- **Warm-up:** WIN=5, ADDR_WIDTH=4, push samples 1..5 back-to-back, win_ready=1 → no win_valid during samples 1–4; after sample 5, win_data sequence 1,2,3,4,5 with first on 1 and last on 5; in_ready low for exactly 5 cycles.
- **Sliding:** continue with samples 6, 7 → windows 2..6 then 3..7; ram_wr_addr = 5 then 6.
- **Wrap:** push samples 1..20 → the window after sample 18 reads addresses 13,14,15,0,1 and yields data 14..18.
- **Backpressure:** during a window, hold win_ready=0 for 3 cycles on the third word → win_data stays 3 and win_valid stays 1; in_ready stays 0; the window completes in order.
- **Flush:** flush mid-READ → win_valid=0 next cycle and state IDLE; the next 4 samples produce no output; the 5th produces a window containing only the post-flush samples.
- **Reset:** assert asyn_rst mid-READ without a clock edge → all outputs go immediately to their reset values (win_valid=0, in_ready=1, ram_wr_en=0); after release, the first write goes to address 0.
